div_operand_mux_reg: RTL and testbench

- Parametrised, registered successor to the combinational operand/remainder select in the signed divider datapath.
- Loads a sign- or zero-extended dividend-side operand on Start, then takes partial-remainder feedback from the subtractor stage for a fixed number of iteration steps.
- Flags completion with a one-cycle Done pulse.
- Sits between the operand input and the divider's add/subtract stage, and replaces the open-coded select plus external step counter.

---
 rtl/div_operand_mux_reg.sv | 100 ++++++++++
 tb/tb_div_operand_mux_reg.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/div_operand_mux_reg.sv
// div_operand_mux_reg: registered operand / partial-remainder select for the
// signed divider. It loads an extended A on Start and then accepts STEPS
// feedback words on B. After the last word it raises a one-cycle Done pulse.
// Optional build macro: ABORT_EN adds an Abort input that cancels a running
// operation.
module div_operand_mux_reg #(
    parameter int unsigned A_WIDTH = 4,
    parameter int unsigned B_WIDTH = 6,
    parameter int unsigned STEPS   = 4,
    parameter int unsigned CNT_W   = $clog2(STEPS + 1)
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic [A_WIDTH-1:0] A,
    input  logic               A_Signed,
    input  logic [B_WIDTH-1:0] B,
    input  logic               B_Valid,
`ifdef ABORT_EN
    input  logic               Abort,
`endif
    output logic [B_WIDTH-1:0] MUX_Out,
    output logic               Busy,
    output logic               Done,
    output logic [CNT_W-1:0]   Step_Count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(STEPS - 1);

    state_t             state;
    logic [B_WIDTH-1:0] ext_a;
    logic               abort_req;

`ifdef ABORT_EN
    assign abort_req = Abort;
`else
    assign abort_req = 1'b0;
`endif

    // Widen A to the datapath width; equal widths pass straight through
    generate
        if (B_WIDTH > A_WIDTH) begin : g_ext
            always_comb ext_a = {{(B_WIDTH - A_WIDTH){A_Signed & A[A_WIDTH-1]}}, A};
        end else begin : g_noext
            always_comb ext_a = B_WIDTH'(A);
        end
    endgenerate

    // Control FSM and registered outputs; Done defaults low so it pulses once
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state      <= IDLE;
            MUX_Out    <= '0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Step_Count <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                RUN: begin
                    if (abort_req) begin
                        // cancel: outputs hold, no completion pulse
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end else if (B_Valid) begin
                        MUX_Out    <= B;
                        Step_Count <= Step_Count + CNT_W'(1);
                        if (Step_Count == LAST_IDX) begin
                            state <= DONE;
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                        end
                    end
                end
                IDLE, DONE: begin
                    // DONE accepts Start like IDLE for back-to-back operations
                    if (Start) begin
                        state      <= RUN;
                        MUX_Out    <= ext_a;
                        Step_Count <= '0;
                        Busy       <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_operand_mux_reg.sv
// Testbench for div_operand_mux_reg. It runs the directed cases, then random
// traffic, and compares every cycle against a behavioural model.
module tb_div_operand_mux_reg;

    localparam int unsigned AW = 4;
    localparam int unsigned BW = 6;
    localparam int unsigned ST = 4;
    localparam int unsigned CW = $clog2(ST + 1);

    logic          Clock = 1'b0;
    logic          Reset;
    logic          Start;
    logic [AW-1:0] A;
    logic          A_Signed;
    logic [BW-1:0] B;
    logic          B_Valid;
    logic          Abort;
    logic [BW-1:0] MUX_Out;
    logic          Busy;
    logic          Done;
    logic [CW-1:0] Step_Count;

    int errors = 0;
    int checks = 0;

    // model state: phase 0 = idle, 1 = running, 2 = completion cycle
    int m_phase = 0;
    int m_out   = 0;
    int m_cnt   = 0;
    int m_busy  = 0;
    int m_done  = 0;

    always #5 Clock = ~Clock;

    div_operand_mux_reg #(.A_WIDTH(AW), .B_WIDTH(BW), .STEPS(ST)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start      (Start),
        .A          (A),
        .A_Signed   (A_Signed),
        .B          (B),
        .B_Valid    (B_Valid),
`ifdef ABORT_EN
        .Abort      (Abort),
`endif
        .MUX_Out    (MUX_Out),
        .Busy       (Busy),
        .Done       (Done),
        .Step_Count (Step_Count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Extension done with arithmetic: a negative signed A is offset by 2^BW - 2^AW
    function automatic int extend(input int a, input bit sgn);
        if (sgn && a >= (1 << (AW - 1))) return a + (1 << BW) - (1 << AW);
        return a;
    endfunction

    // Advance the model by one edge using the current inputs.
    // Then let the DUT take the edge and compare all of its outputs.
    task automatic tick();
        bit abort_on;
`ifdef ABORT_EN
        abort_on = (Abort === 1'b1);
`else
        abort_on = 1'b0;
`endif
        if (!Reset) begin
            m_phase = 0; m_out = 0; m_cnt = 0; m_busy = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (m_phase == 1) begin
                if (abort_on) begin
                    m_phase = 0; m_busy = 0;
                end else if (B_Valid) begin
                    m_out = int'(B);
                    m_cnt = m_cnt + 1;
                    if (m_cnt == int'(ST)) begin
                        m_phase = 2; m_busy = 0; m_done = 1;
                    end
                end
            end else if (Start) begin
                m_phase = 1; m_out = extend(int'(A), A_Signed); m_cnt = 0; m_busy = 1;
            end else begin
                m_phase = 0;
            end
        end
        @(posedge Clock);
        #1;
        check("mux_out", 32'(MUX_Out), 32'(m_out));
        check("busy",    32'(Busy),    32'(m_busy));
        check("done",    32'(Done),    32'(m_done));
        check("step_cnt", 32'(Step_Count), 32'(m_cnt));
    endtask

    task automatic drive(input bit s, input logic [AW-1:0] a, input bit sg,
                         input logic [BW-1:0] b, input bit bv);
        Start = s; A = a; A_Signed = sg; B = b; B_Valid = bv;
    endtask

    initial begin
        Abort = 1'b0;
        Reset = 1'b0;
        drive(1, 4'hF, 1, 6'h3F, 1);
        tick();
        tick();
        check("rst_out", 32'(MUX_Out), 32'h0);

        // zero-extended load
        Reset = 1'b1;
        drive(1, 4'b1010, 0, 6'h00, 0);
        tick();
        check("load_zext", 32'(MUX_Out), 32'(6'b001010));
        check("load_busy", 32'(Busy), 32'h1);
        Reset = 1'b0; drive(0, 0, 0, 0, 0); tick(); Reset = 1'b1;

        // sign-extended load, then four consecutive feedback words
        drive(1, 4'b1010, 1, 6'h00, 0);
        tick();
        check("load_sext", 32'(MUX_Out), 32'(6'b111010));
        for (int i = 1; i <= 4; i++) begin
            drive(0, 0, 0, BW'(i), 1);
            tick();
            check("seq_cnt", 32'(Step_Count), 32'(i));
        end
        check("seq_done", 32'(Done), 32'h1);
        check("seq_last", 32'(MUX_Out), 32'h04);
        drive(0, 0, 0, 0, 0);
        tick();
        check("done_pulse_once", 32'(Done), 32'h0);

        // stall of three cycles with an ignored Start in the middle
        drive(1, 4'h5, 0, 0, 0); tick();
        drive(0, 0, 0, 6'h01, 1); tick();
        drive(0, 0, 0, 6'h02, 1); tick();
        for (int i = 0; i < 3; i++) begin
            drive(i == 1, 4'hC, 1, 6'h2A, 0);
            tick();
            check("stall_out", 32'(MUX_Out), 32'h02);
            check("stall_cnt", 32'(Step_Count), 32'h2);
        end
        drive(0, 0, 0, 6'h03, 1); tick();
        drive(0, 0, 0, 6'h04, 1); tick();
        check("stall_done", 32'(Done), 32'h1);

        // back-to-back start from the completion cycle
        drive(1, 4'h3, 0, 6'h3F, 1); tick();
        check("b2b_out", 32'(MUX_Out), 32'h03);
        check("b2b_cnt", 32'(Step_Count), 32'h0);
        drive(0, 0, 0, 6'h11, 1); tick();
        drive(0, 0, 0, 6'h12, 1); tick();
        Reset = 1'b0; drive(0, 0, 0, 6'h13, 1); tick();
        check("abort_rst_busy", 32'(Busy), 32'h0);
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) tick();

`ifdef ABORT_EN
        drive(1, 4'h7, 0, 0, 0); tick();
        for (int i = 1; i <= 3; i++) begin drive(0, 0, 0, BW'(i + 8), 1); tick(); end
        Abort = 1'b1; drive(1, 4'h1, 0, 6'h3E, 1); tick();
        Abort = 1'b0;
        check("abort_cnt", 32'(Step_Count), 32'h3);
        check("abort_out", 32'(MUX_Out), 32'h0B);
        drive(1, 4'h6, 0, 0, 0); tick();
        check("abort_restart", 32'(MUX_Out), 32'h06);
`endif

        // random traffic
        for (int i = 0; i < 600; i++) begin
            Reset = ($urandom_range(0, 40) != 0);
            drive($urandom_range(0, 3) == 0, AW'($urandom), 1'($urandom),
                  BW'($urandom), $urandom_range(0, 2) != 0);
`ifdef ABORT_EN
            Abort = ($urandom_range(0, 15) == 0);
`endif
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
